multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the multicycle MIPS datapath; sits directly upstream of ALU_Control.
//  Decodes opcode, sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and alu_op[1:0].
//  ALU_Control combines alu_op with funct: 00=add, 01=sub, 10=use funct, 11=or.
//  Memory accesses stall on a mem_ready handshake.
// PARAMETERS
//  WAIT_MEM   1   1: FETCH/MEM_RD/MEM_WR hold until mem_ready=1; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous reset, active low
//  opcode         in   6  instr[31:26] from IR (valid from DECODE onward)
//  mem_ready      in   1  memory has completed the current access
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  i_or_d         out  1  0: address=PC, 1: address=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load IR
//  mem_to_reg     out  1  1: write-back data = MDR
//  reg_dst        out  1  1: dest=rd, 0: dest=rt
//  reg_write      out  1  register file write enable
//  alu_src_a      out  1  0: PC, 1: reg A
//  alu_src_b      out  2  00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
//  alu_op         out  2  to ALU_Control
//  pc_source      out  2  00: ALU result, 01: ALUOut, 10: jump target
//  instr_done     out  1  one-cycle pulse in last state of each instruction
//  illegal_op     out  1  one-cycle pulse in DECODE for unsupported opcode
// BEHAVIOUR
//  - Opcodes: R=000000 lw=100011 sw=101011 beq=000100 j=000010 addi=001000 ori=001101.
//  - Outputs Moore-decoded from state; all unlisted outputs 0 in a state.
//  - Handshake outputs (pc_write, ir_write) additionally gated by mem_ready.
//  - Reset (rst_n=0): state=FETCH immediately; all outputs 0 while rst_n=0.
//    After release, first edge is a normal FETCH.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//    ir_write=pc_write=mem_ready. Advance to DECODE only when mem_ready.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target -> ALUOut). Next state by opcode:
//    lw/sw->MEM_ADDR, R->R_EXEC, beq->BRANCH, j->JUMP, addi/ori->I_EXEC, other->FETCH (illegal_op=1).
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready.
//    instr_done=mem_ready; then FETCH.
//  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB (reg_write=1, reg_dst=1, instr_done=1) -> FETCH.
//  - I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) or 11 (ori) -> I_WB.
//    I_WB: reg_write=1, reg_dst=0, instr_done=1; then FETCH.
//    I_EXEC->I_WB uses latched op class.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
//  - JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
//  - Op class latched in DECODE into a 3-bit reg; later states use it, not opcode (IR may be unstable).
//  - Latency with mem_ready=1: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3, illegal 2.
//  - mem_read and mem_write never both 1.
//  - Unreachable state encodings -> FETCH next cycle, outputs 0.
//  - rst_n low mid-instruction aborts it; no write enable asserts until after FETCH completes.
// STRUCTURE
//  Shared package: opcode constants, state enum (4-bit), alu_op codes (ALU_ADD=00 ALU_SUB=01 ALU_FUNCT=10 ALU_OR=11),
//    alu_src_b and pc_source encodings; ALU_Control imports the alu_op codes from the same package.
//  One sub-module natural: multicycle_control_decode (combinational state->output table); FSM register in top.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles mid-lw -> all outputs 0; release -> FETCH, mem_read=1, pc_write=1.
//  2. R-type: opcode=000000, mem_ready=1 -> alu_op=10 in cycle 3, reg_write=1 & reg_dst=1 in cycle 4, instr_done in cycle 4.
//  3. lw with mem_ready low 3 cycles in MEM_RD -> state held, mem_read=1, i_or_d=1; total latency 8; mem_to_reg=1 at WB.
//  4. beq 000100 -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01; j 000010 -> pc_write=1, pc_source=10; each 3 cycles.
//  5. ori 001101 -> alu_op=11 in I_EXEC, reg_write=1 & reg_dst=0 next; addi -> alu_op=00.
//  6. opcode=111111 -> illegal_op pulse in DECODE, back to FETCH next cycle, no reg_write/mem_write ever.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU operation codes and mux selects, plus the opcode-to-class decoder.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // Also consumed by ALU_Control
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] ASB_REG_B   = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_LW   = 3'd0,
        CLS_SW   = 3'd1,
        CLS_R    = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_J    = 3'd4,
        CLS_ADDI = 3'd5,
        CLS_ORI  = 3'd6,
        CLS_ILL  = 3'd7
    } op_cls_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic op_cls_t decode_opcode(input logic [5:0] op);
        op_cls_t cls;
        case (op)
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_RTYPE: cls = CLS_R;
            OP_BEQ:   cls = CLS_BEQ;
            OP_J:     cls = CLS_J;
            OP_ADDI:  cls = CLS_ADDI;
            OP_ORI:   cls = CLS_ORI;
            default:  cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the main FSM (master) and the datapath (slave).
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op
    );

endinterface

// File: rtl/multicycle_control_decode.sv
// Moore output table for the multicycle control FSM; DECODE additionally flags
// unsupported opcodes and the memory handshake gates the fetch/store strobes.
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_t  state,
    input  op_cls_t cls_q,
    input  op_cls_t cls_dec,
    input  logic    mem_ready,
    output ctrl_t   ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ASB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding
                ctrl.alu_src_b  = ASB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = (cls_dec == CLS_ILL);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_REG_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                // IR may already be changing, so the latched class picks the ALU op
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.alu_op    = (cls_q == CLS_ORI) ? ALU_OR : ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ASB_REG_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and alu_op.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t  state;
    op_cls_t cls_q;
    op_cls_t cls_dec;
    logic    mem_rdy;
    ctrl_t   ctrl;
    ctrl_t   ctrl_out;

    assign mem_rdy = WAIT_MEM ? bus.mem_ready : 1'b1;
    assign cls_dec = decode_opcode(bus.opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cls_q <= CLS_ILL;
        end else begin
            case (state)
                S_FETCH:  if (mem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    cls_q <= cls_dec;
                    case (cls_dec)
                        CLS_LW, CLS_SW:     state <= S_MEM_ADDR;
                        CLS_R:              state <= S_R_EXEC;
                        CLS_BEQ:            state <= S_BRANCH;
                        CLS_J:              state <= S_JUMP;
                        CLS_ADDI, CLS_ORI:  state <= S_I_EXEC;
                        default:            state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: state <= (cls_q == CLS_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_rdy) state <= S_MEM_WB;
                S_MEM_WB:   state <= S_FETCH;
                S_MEM_WR:   if (mem_rdy) state <= S_FETCH;
                S_R_EXEC:   state <= S_R_WB;
                S_R_WB:     state <= S_FETCH;
                S_I_EXEC:   state <= S_I_WB;
                S_I_WB:     state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    multicycle_control_decode u_decode (
        .state     (state),
        .cls_q     (cls_q),
        .cls_dec   (cls_dec),
        .mem_ready (mem_rdy),
        .ctrl      (ctrl)
    );

    // Outputs are forced quiet for as long as reset is held, not just at the edge
    assign ctrl_out = rst_n ? ctrl : '0;

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.instr_done    = ctrl_out.instr_done;
    assign bus.illegal_op    = ctrl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: each cycle compares the full
// control word against a hand-built expectation.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.WAIT_MEM(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Control word: pw pwc iod mr mw irw m2r rd rw asa asb[2] aop[2] psrc[2] done ill
    logic [17:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_source, bus.instr_done, bus.illegal_op};

    localparam logic [17:0] PW   = 18'(1) << 17;
    localparam logic [17:0] PWC  = 18'(1) << 16;
    localparam logic [17:0] IOD  = 18'(1) << 15;
    localparam logic [17:0] MR   = 18'(1) << 14;
    localparam logic [17:0] MW   = 18'(1) << 13;
    localparam logic [17:0] IRW  = 18'(1) << 12;
    localparam logic [17:0] M2R  = 18'(1) << 11;
    localparam logic [17:0] RD   = 18'(1) << 10;
    localparam logic [17:0] RW   = 18'(1) << 9;
    localparam logic [17:0] ASA  = 18'(1) << 8;
    localparam logic [17:0] B4   = 18'(1) << 6;
    localparam logic [17:0] BIMM = 18'(2) << 6;
    localparam logic [17:0] BSH2 = 18'(3) << 6;
    localparam logic [17:0] ASUB = 18'(1) << 4;
    localparam logic [17:0] AFN  = 18'(2) << 4;
    localparam logic [17:0] AOR  = 18'(3) << 4;
    localparam logic [17:0] PSO  = 18'(1) << 2;
    localparam logic [17:0] PSJ  = 18'(2) << 2;
    localparam logic [17:0] DONE = 18'(1) << 1;
    localparam logic [17:0] ILL  = 18'(1);

    localparam logic [17:0] E_FETCH    = PW | MR | IRW | B4;
    localparam logic [17:0] E_FETCH_NR = MR | B4;
    localparam logic [17:0] E_DECODE   = BSH2;
    localparam logic [17:0] E_MADDR    = ASA | BIMM;
    localparam logic [17:0] E_MRD      = MR | IOD;
    localparam logic [17:0] E_MWB      = RW | M2R | DONE;
    localparam logic [17:0] E_MWR_NR   = MW | IOD;
    localparam logic [17:0] E_MWR      = MW | IOD | DONE;
    localparam logic [17:0] E_REXEC    = ASA | AFN;
    localparam logic [17:0] E_RWB      = RW | RD | DONE;
    localparam logic [17:0] E_ADDI     = ASA | BIMM;
    localparam logic [17:0] E_ORI      = ASA | BIMM | AOR;
    localparam logic [17:0] E_IWB      = RW | DONE;
    localparam logic [17:0] E_BRANCH   = ASA | ASUB | PWC | PSO | DONE;
    localparam logic [17:0] E_JUMP     = PW | PSJ | DONE;

    localparam logic [5:0] OPR   = 6'b000000;
    localparam logic [5:0] OPLW  = 6'b100011;
    localparam logic [5:0] OPSW  = 6'b101011;
    localparam logic [5:0] OPBEQ = 6'b000100;
    localparam logic [5:0] OPJ   = 6'b000010;
    localparam logic [5:0] OPADD = 6'b001000;
    localparam logic [5:0] OPORI = 6'b001101;
    localparam logic [5:0] OPBAD = 6'b111111;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, check this cycle, advance one cycle
    task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                        input logic [17:0] exp);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        check(tag, obs, exp);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OPLW;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1 check("rst_init", obs, 18'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw aborted by reset while in MEM_RD
        step("lw_abort_fetch",  OPLW, 1'b1, E_FETCH);
        step("lw_abort_decode", OPLW, 1'b1, E_DECODE);
        step("lw_abort_maddr",  OPLW, 1'b1, E_MADDR);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("rst_mid", obs, 18'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;

        // R-type
        step("r_fetch",  OPR, 1'b1, E_FETCH);
        step("r_decode", OPR, 1'b1, E_DECODE);
        step("r_exec",   OPR, 1'b1, E_REXEC);
        step("r_wb",     OPR, 1'b1, E_RWB);

        // lw with three stall cycles in MEM_RD
        step("lw_fetch",  OPLW, 1'b1, E_FETCH);
        step("lw_decode", OPLW, 1'b1, E_DECODE);
        step("lw_maddr",  OPLW, 1'b1, E_MADDR);
        for (int i = 0; i < 3; i++) step("lw_rd_stall", OPLW, 1'b0, E_MRD);
        step("lw_rd",     OPLW, 1'b1, E_MRD);
        step("lw_wb",     OPLW, 1'b1, E_MWB);

        // sw with a fetch stall and a store stall
        step("sw_fetch_stall", OPSW, 1'b0, E_FETCH_NR);
        step("sw_fetch",       OPSW, 1'b1, E_FETCH);
        step("sw_decode",      OPSW, 1'b1, E_DECODE);
        step("sw_maddr",       OPSW, 1'b1, E_MADDR);
        step("sw_wr_stall",    OPSW, 1'b0, E_MWR_NR);
        step("sw_wr",          OPSW, 1'b1, E_MWR);

        // beq and j
        step("beq_fetch",  OPBEQ, 1'b1, E_FETCH);
        step("beq_decode", OPBEQ, 1'b1, E_DECODE);
        step("beq_branch", OPBEQ, 1'b1, E_BRANCH);
        step("j_fetch",    OPJ,   1'b1, E_FETCH);
        step("j_decode",   OPJ,   1'b1, E_DECODE);
        step("j_jump",     OPJ,   1'b1, E_JUMP);

        // ori with opcode scrambled after DECODE, then addi
        step("ori_fetch",  OPORI, 1'b1, E_FETCH);
        step("ori_decode", OPORI, 1'b1, E_DECODE);
        step("ori_exec",   OPBAD, 1'b1, E_ORI);
        step("ori_wb",     OPBAD, 1'b1, E_IWB);
        step("addi_fetch", OPADD, 1'b1, E_FETCH);
        step("addi_decode",OPADD, 1'b1, E_DECODE);
        step("addi_exec",  OPORI, 1'b1, E_ADDI);
        step("addi_wb",    OPORI, 1'b1, E_IWB);

        // illegal opcode returns to FETCH straight after DECODE
        step("ill_fetch",  OPBAD, 1'b1, E_FETCH);
        step("ill_decode", OPBAD, 1'b1, E_DECODE | ILL);
        step("ill_refetch",OPBAD, 1'b1, E_FETCH);
        step("ill_decode2",OPJ,   1'b1, E_DECODE);
        step("post_jump",  OPJ,   1'b1, E_JUMP);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
